// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state and owner-tag encodings for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_BOOT = 2'd0,
        ARB_RUN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INS  = 2'd1,
        OWN_DAT  = 2'd2,
        OWN_HST  = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - saturating count of cycles an instruction fetch has waited
module mem_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic ins_req,
    input  logic ins_gnt,
    output logic at_limit
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst || !run || !ins_req || ins_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign at_limit = (starve_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - three-way arbiter for a shared one-cycle-latency SRAM with boot and host lock
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ins_req,
    input  logic [ADDR_WIDTH-1:0] i_ins_addr,
    input  logic                  i_dat_req,
    input  logic                  i_dat_we,
    input  logic [3:0]            i_dat_be,
    input  logic [ADDR_WIDTH-1:0] i_dat_addr,
    input  logic [DATA_WIDTH-1:0] i_dat_wdata,
    input  logic                  i_hst_req,
    input  logic                  i_hst_we,
    input  logic [3:0]            i_hst_be,
    input  logic [ADDR_WIDTH-1:0] i_hst_addr,
    input  logic [DATA_WIDTH-1:0] i_hst_wdata,
    input  logic                  i_hst_lock,
    input  logic                  i_boot_done,
    output logic                  o_ins_gnt,
    output logic                  o_dat_gnt,
    output logic                  o_hst_gnt,
    output logic                  o_ins_rvalid,
    output logic                  o_dat_rvalid,
    output logic                  o_hst_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_core_hold,
    output logic                  o_mem_en,
    output logic [3:0]            o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    arb_state_t state, state_nxt;
    owner_t     owner;
    logic       at_limit;

    mem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .run      (state == ARB_RUN),
        .ins_req  (i_ins_req),
        .ins_gnt  (o_ins_gnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_BOOT: if (i_boot_done) state_nxt = ARB_RUN;
            ARB_RUN:  if (i_hst_lock)  state_nxt = ARB_LOCK;
            ARB_LOCK: if (!i_hst_lock) state_nxt = ARB_RUN;
            default:  state_nxt = ARB_BOOT;
        endcase
    end

    // Grants are combinational so a request is issued in the cycle it appears.
    always_comb begin
        o_ins_gnt   = 1'b0;
        o_dat_gnt   = 1'b0;
        o_hst_gnt   = 1'b0;
        o_core_hold = (state != ARB_RUN);
        if (!rst) begin
            if (i_hst_req) begin
                o_hst_gnt = 1'b1;
            end else if (state == ARB_RUN) begin
                if (at_limit && i_ins_req) begin
                    o_ins_gnt = 1'b1;
                end else if (i_dat_req) begin
                    o_dat_gnt = 1'b1;
                end else if (i_ins_req) begin
                    o_ins_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 4'h0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (o_hst_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_hst_we ? i_hst_be : 4'h0;
            o_mem_addr  = i_hst_addr;
            o_mem_wdata = i_hst_wdata;
        end else if (o_dat_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_dat_we ? i_dat_be : 4'h0;
            o_mem_addr  = i_dat_addr;
            o_mem_wdata = i_dat_wdata;
        end else if (o_ins_gnt) begin
            o_mem_en    = 1'b1;
            o_mem_addr  = i_ins_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (o_ins_gnt) begin
            owner <= OWN_INS;
        end else if (o_dat_gnt && !i_dat_we) begin
            owner <= OWN_DAT;
        end else if (o_hst_gnt && !i_hst_we) begin
            owner <= OWN_HST;
        end else begin
            owner <= OWN_NONE;
        end
    end

    // A reset arriving while a read is in flight suppresses its return.
    assign o_ins_rvalid = !rst && (owner == OWN_INS);
    assign o_dat_rvalid = !rst && (owner == OWN_DAT);
    assign o_hst_rvalid = !rst && (owner == OWN_HST);
    assign o_rdata      = i_mem_rdata;

endmodule
